// File: rtl/gates.sv
// gates: two-input logic-gate bank with a registered, change-flagged copy.
//   y[0]=a|b  y[1]=a&b  y[2]=~(a|b)  y[3]=~(a&b)
//   y[4]=a^b  y[5]=~(a^b)  y[6]=~a  y[7]=~b
// Optional feature macro: GATES_CNT_EN adds the saturating chg_cnt output.
// Reset asserts asynchronously; release passes through a 2-flop synchroniser,
// so the data registers first capture on the third rising edge after rst_n rises.
module gates #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    output logic [7:0]       y,
    output logic [7:0]       y_q,
    output logic             y_vld,
    output logic             chg
`ifdef GATES_CNT_EN
    ,
    output logic [CNT_W-1:0] chg_cnt
`endif
);

    if (CNT_W < 4 || CNT_W > 32) begin : g_bad_cnt_w
        $error("gates: CNT_W must lie in 4..32");
    end

    logic [1:0] rst_sync;
    logic       rst_int_n;
    logic       nxt_chg;

    // Gate bank: purely combinational, untouched by reset.
    always_comb begin
        y    = 8'h00;
        y[0] = a | b;
        y[1] = a & b;
        y[2] = ~(a | b);
        y[3] = ~(a & b);
        y[4] = a ^ b;
        y[5] = ~(a ^ b);
        y[6] = ~a;
        y[7] = ~b;
    end

    // Reset synchroniser: asynchronous assert, two-edge release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    // A change only counts once y_q already holds a real sample.
    assign nxt_chg = y_vld && (y != y_q);

    // Sample register with valid and change-detect flags.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            y_q   <= 8'h00;
            y_vld <= 1'b0;
            chg   <= 1'b0;
        end else begin
            y_q   <= y;
            y_vld <= 1'b1;
            chg   <= nxt_chg;
        end
    end

`ifdef GATES_CNT_EN
    // Saturating change counter, advanced on the same edge that sets chg.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            chg_cnt <= '0;
        end else if (nxt_chg && (chg_cnt != {CNT_W{1'b1}})) begin
            chg_cnt <= chg_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gates.sv
// Self-checking bench for gates; expected registered outputs are queued
// when stimulus is applied and compared #1 after the following rising edge.
module tb_gates;

    localparam int TB_CNT_W = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                a;
    logic                b;
    logic [7:0]          y;
    logic [7:0]          y_q;
    logic                y_vld;
    logic                chg;
`ifdef GATES_CNT_EN
    logic [TB_CNT_W-1:0] chg_cnt;
`endif

    gates #(.CNT_W(TB_CNT_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .y      (y),
        .y_q    (y_q),
        .y_vld  (y_vld),
        .chg    (chg)
`ifdef GATES_CNT_EN
        ,
        .chg_cnt(chg_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  yq;
        logic        vld;
        logic        chg;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_rel;
    logic [7:0]  m_yq;
    logic        m_vld;
    int unsigned m_cnt;

    function automatic logic [7:0] gate_ref(input logic ia, input logic ib);
        case ({ia, ib})
            2'b00:   return 8'hEC;
            2'b01:   return 8'h59;
            2'b10:   return 8'h99;
            default: return 8'h23;
        endcase
    endfunction

    task automatic model_reset();
        m_rel = 0;
        m_yq  = 8'h00;
        m_vld = 1'b0;
        m_cnt = 0;
    endtask

    // One clock: drive inputs, push expectation, take edge, pop and compare.
    task automatic cycle(input logic na, input logic nb, input string tag);
        exp_t e;
        exp_t got;
        logic [7:0] g;
        logic c;
        a = na;
        b = nb;
        #1;
        g = gate_ref(na, nb);
        checks++;
        if (y !== g) begin
            errors++;
            $display("FAIL %s y: got %h want %h", tag, y, g);
        end
        if (m_rel == 2) begin
            c = m_vld && (g != m_yq);
            if (c && m_cnt < (1 << TB_CNT_W) - 1) m_cnt++;
            m_yq  = g;
            m_vld = 1'b1;
        end else begin
            c = 1'b0;
            m_rel++;
        end
        e.yq  = m_yq;
        e.vld = m_vld;
        e.chg = c;
        e.cnt = m_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            got = exp_q.pop_front();
            if (y_q !== got.yq || y_vld !== got.vld || chg !== got.chg) begin
                errors++;
                $display("FAIL %s regs: got y_q=%h vld=%b chg=%b want y_q=%h vld=%b chg=%b",
                         tag, y_q, y_vld, chg, got.yq, got.vld, got.chg);
            end
`ifdef GATES_CNT_EN
            checks++;
            if (32'(chg_cnt) !== got.cnt) begin
                errors++;
                $display("FAIL %s chg_cnt: got %0d want %0d", tag, chg_cnt, got.cnt);
            end
`endif
        end
    endtask

    task automatic check_cleared(input string tag);
        checks++;
        if (y_q !== 8'h00 || y_vld !== 1'b0 || chg !== 1'b0) begin
            errors++;
            $display("FAIL %s: got y_q=%h vld=%b chg=%b want y_q=00 vld=0 chg=0",
                     tag, y_q, y_vld, chg);
        end
`ifdef GATES_CNT_EN
        checks++;
        if (chg_cnt !== '0) begin
            errors++;
            $display("FAIL %s chg_cnt: got %0d want 0", tag, chg_cnt);
        end
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a = 1'b1;
        b = 1'b1;
        model_reset();
        #2;
        checks++;
        if (y !== 8'h23) begin
            errors++;
            $display("FAIL reset_y: got %h want 23", y);
        end
        check_cleared("reset_regs");
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset_held");
    endtask

    task automatic test_truth_table();
        logic [7:0] want [4];
        want[0] = 8'hEC;
        want[1] = 8'h59;
        want[2] = 8'h99;
        want[3] = 8'h23;
        for (int i = 0; i < 4; i++) begin
            a = i[1];
            b = i[0];
            #2;
            checks++;
            if (y !== want[i]) begin
                errors++;
                $display("FAIL truth_%0d%0d: got %h want %h", i[1], i[0], y, want[i]);
            end
        end
    endtask

    task automatic test_latency();
        a = 1'b0;
        b = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_rel = 0;
        cycle(1'b0, 1'b0, "rel_edge1");
        cycle(1'b0, 1'b0, "rel_edge2");
        cycle(1'b0, 1'b0, "first_sample");
        checks++;
        if (y_q !== 8'hEC || y_vld !== 1'b1 || chg !== 1'b0) begin
            errors++;
            $display("FAIL latency_abs: got y_q=%h vld=%b chg=%b want EC 1 0", y_q, y_vld, chg);
        end
        cycle(1'b1, 1'b0, "a_rise");
        checks++;
        if (y_q !== 8'h99 || chg !== 1'b1) begin
            errors++;
            $display("FAIL a_rise_abs: got y_q=%h chg=%b want 99 1", y_q, chg);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, "hold");
        checks++;
        if (y_q !== 8'h99 || chg !== 1'b0) begin
            errors++;
            $display("FAIL hold_abs: got y_q=%h chg=%b want 99 0", y_q, chg);
        end
    endtask

    task automatic test_toggle();
        for (int i = 0; i < 6; i++) cycle(logic'(i[0]), 1'b1, "toggle_a");
        for (int i = 0; i < 4; i++) cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, "random");
    endtask

    task automatic test_mid_reset();
        cycle(1'b0, 1'b1, "pre_rst0");
        cycle(1'b1, 1'b1, "pre_rst1");
        #2;
        a = 1'b0;
        rst_n = 1'b0;
        #1;
        check_cleared("mid_reset");
        model_reset();
        #2;
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, "post_edge1");
        cycle(1'b0, 1'b0, "post_edge2");
        cycle(1'b1, 1'b1, "post_first");
        checks++;
        if (chg !== 1'b0 || y_vld !== 1'b1 || y_q !== 8'h23) begin
            errors++;
            $display("FAIL post_first_abs: got y_q=%h vld=%b chg=%b want 23 1 0", y_q, y_vld, chg);
        end
        cycle(1'b0, 1'b1, "post_second");
    endtask

`ifdef GATES_CNT_EN
    task automatic test_cnt_sat();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_cleared("cnt_reset");
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, "cnt_edge1");
        cycle(1'b0, 1'b0, "cnt_edge2");
        for (int i = 0; i < 20; i++) cycle(1'b0, logic'(i[0]), "cnt_toggle_b");
        checks++;
        if (chg_cnt !== 4'd15) begin
            errors++;
            $display("FAIL cnt_saturate: got %0d want 15", chg_cnt);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_truth_table();
        test_latency();
        test_hold();
        test_toggle();
        test_mid_reset();
`ifdef GATES_CNT_EN
        test_cnt_sat();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gates.md
Name: gates

Overview:
- Two-input logic-gate bank producing OR, AND, NOR, NAND, XOR, XNOR, NOT a and NOT b as one 8-bit result vector.
- The result is available combinationally on y and as a one-cycle registered copy on y_q, with valid and change-detect flags.
- Used as a small reference/bring-up block and as a gate-level sanity checker in the design.

Parameters:
- CNT_W, 16, width of the optional change counter (applies only when GATES_CNT_EN is defined); legal range 4..32.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  1  gate operand A.
- b  input  1  gate operand B.
- y  output  8  combinational gate results, zero latency.
- y_q  output  8  registered copy of y.
- y_vld  output  1  y_q holds a real sample.
- chg  output  1  single-cycle pulse when y_q took a new value.
- chg_cnt  output  CNT_W  saturating count of chg pulses; present only with GATES_CNT_EN.

Behaviour:
- y bit map, purely combinational from a and b with no clock dependence:
  - y[0] = a|b
  - y[1] = a&b
  - y[2] = ~(a|b)
  - y[3] = ~(a&b)
  - y[4] = a^b
  - y[5] = ~(a^b)
  - y[6] = ~a
  - y[7] = ~b
- y settles within the same delta/timestep as an input change. A bench sampling any time after the change sees the new value.
- X or Z on a or b propagates per standard operator semantics; no masking.
- Reset (rst_n=0, asynchronous assert):
  - y_q = 8'h00, y_vld = 0, chg = 0, chg_cnt = 0.
  - y is unaffected by reset.
- Reset deassertion is synchronised internally (2-flop release). Registers leave reset on the second rising clk edge after rst_n rises.
- Every rising clk edge out of reset:
  - y_q <= y (1-cycle latency).
  - y_vld <= 1; it stays 1 until the next reset.
  - chg <= 1 iff y_vld was already 1 and y differs from the current y_q; otherwise chg <= 0.
- The first capture after reset never raises chg; the 8'h00 reset value is not a real sample.
- Inputs held constant: y_q stable, chg = 0.
- Inputs toggling every cycle: chg = 1 every cycle from the second valid sample onward.
- Reset asserted mid-operation: all registers clear immediately, independent of clk.

Optional Feature:
- Macro: GATES_CNT_EN.
- Defined:
  - chg_cnt port exists.
  - chg_cnt increments by 1 on each cycle where chg is being asserted, i.e. at the same edge that sets chg.
  - It saturates at 2^CNT_W-1 and never wraps.
  - It clears on reset.
- Undefined: chg_cnt port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Static truth table, no clock needed: a,b = 00/01/10/11, each sampled 2 time units after the change -> y = 8'hEC / 8'h59 / 8'h99 / 8'h23.
- Reset: drive rst_n=0 with a=1,b=1 -> y = 8'h23 immediately; y_q = 8'h00, y_vld = 0, chg = 0 (chg_cnt = 0 if enabled).
- Latency:
  - Release reset with a=0,b=0 held -> y_q = 8'hEC one cycle after the registers leave reset, y_vld = 1, chg = 0.
  - Then set a=1 -> y_q = 8'h99 next cycle with chg = 1 for exactly one cycle.
- Hold: keep a=1,b=0 for 5 cycles -> y_q stays 8'h99, chg = 0 throughout.
- Mid-operation reset: pulse rst_n low between clock edges while toggling a -> y_q = 8'h00 and y_vld = 0 asynchronously; the first post-release capture gives chg = 0.
- GATES_CNT_EN with CNT_W=4: toggle b every cycle for 20 cycles -> chg_cnt counts 1..15 and stays at 15.
